// File: rtl/dense_axis_bridge_pkg.sv
// Shared definitions for the dense datapath and controller: default frame
// geometry and the bridge state encoding.
package dense_axis_bridge_pkg;

    localparam int unsigned DenseInCount  = 1600;
    localparam int unsigned DenseOutCount = 10;
    localparam int unsigned DenseDataSize = 32;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        FULL = 2'd1,
        SEND = 2'd2
    } denseState_e;

endpackage

// File: rtl/dense_axis_bridge_loop_counter.sv
// LoopCounter: modulo-Count up counter with synchronous clear.
// co flags the last count so callers can decode end-of-frame without
// their own comparator.
module dense_axis_bridge_loop_counter #(
    parameter int unsigned Count = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] cnt,
    output logic             co
);

    assign co = (cnt == Width'(Count - 1));

    // Count register: clear wins over increment, wraps after the last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= co ? '0 : cnt + Width'(1);
        end
    end

endmodule

// File: rtl/dense_axis_bridge.sv
// Bridges an AXI-Stream input frame into a dense-addressable input buffer and
// streams a densely written output buffer back out on AXI-Stream.
module dense_axis_bridge
    import dense_axis_bridge_pkg::*;
#(
    parameter int unsigned IN_COUNT      = DenseInCount,
    parameter int unsigned OUT_COUNT     = DenseOutCount,
    parameter int unsigned DATA_SIZE     = DenseDataSize,
    parameter int unsigned IN_ADR_WIDTH  = 11,
    parameter int unsigned OUT_ADR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_SIZE-1:0]     s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [DATA_SIZE-1:0]     m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    input  logic [IN_ADR_WIDTH-1:0]  bufferIn_adr,
    output logic [DATA_SIZE-1:0]     bufferIn_data,
    input  logic [OUT_ADR_WIDTH-1:0] bufferOut_adr,
    input  logic [DATA_SIZE-1:0]     bufferOut_data,
    input  logic                     bufferOut_we,
    output logic                     gotData,
    input  logic                     putData,
    output logic                     frameErr
);

    logic [DATA_SIZE-1:0] inMem  [IN_COUNT];
    logic [DATA_SIZE-1:0] outMem [OUT_COUNT];

    denseState_e state;
    logic        sReady;
    logic        mValid;
    logic        gotDataReg;
    logic        frameErrReg;

    logic [IN_ADR_WIDTH-1:0]  wrCnt;
    logic                     wrCo;
    logic [OUT_ADR_WIDTH-1:0] rdCnt;
    logic                     rdCo;

    logic sHs;
    logic mHs;

    // sReady is only ever set in RECV, so it doubles as the state qualifier.
    assign sHs = s_axis_tvalid & sReady;
    assign mHs = mValid & m_axis_tready;

    dense_axis_bridge_loop_counter #(
        .Count (IN_COUNT),
        .Width (IN_ADR_WIDTH)
    ) wrCounter (
        .clk (clk),
        .rst (rst),
        .clr (sHs & (wrCo | s_axis_tlast)),
        .inc (sHs),
        .cnt (wrCnt),
        .co  (wrCo)
    );

    dense_axis_bridge_loop_counter #(
        .Count (OUT_COUNT),
        .Width (OUT_ADR_WIDTH)
    ) rdCounter (
        .clk (clk),
        .rst (rst),
        .clr (mHs & rdCo),
        .inc (mHs),
        .cnt (rdCnt),
        .co  (rdCo)
    );

    // Controller: frame sequencing with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RECV;
            sReady      <= 1'b0;
            mValid      <= 1'b0;
            gotDataReg  <= 1'b0;
            frameErrReg <= 1'b0;
        end else begin
            gotDataReg <= 1'b0;
            case (state)
                RECV: begin
                    sReady <= 1'b1;
                    if (sHs) begin
                        if (wrCo) begin
                            // Full count completes the frame even without tlast.
                            state      <= FULL;
                            sReady     <= 1'b0;
                            gotDataReg <= 1'b1;
                            if (!s_axis_tlast) begin
                                frameErrReg <= 1'b1;
                            end
                        end else if (s_axis_tlast) begin
                            // Short frame: dropped, counter restarts at zero.
                            frameErrReg <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (putData) begin
                        state  <= SEND;
                        mValid <= 1'b1;
                    end
                end
                SEND: begin
                    if (mHs && rdCo) begin
                        // Reopen the slave side on the same edge: no bubble.
                        state  <= RECV;
                        mValid <= 1'b0;
                        sReady <= 1'b1;
                    end
                end
                default: begin
                    state  <= RECV;
                    sReady <= 1'b0;
                    mValid <= 1'b0;
                end
            endcase
        end
    end

    // Input buffer capture; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (sHs) begin
            inMem[wrCnt] <= s_axis_tdata;
        end
    end

    // Output buffer fill; frozen while a frame is being transmitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUT_COUNT; i++) begin
                outMem[i] <= '0;
            end
        end else if (bufferOut_we && (state != SEND) && (32'(bufferOut_adr) < OUT_COUNT)) begin
            outMem[bufferOut_adr] <= bufferOut_data;
        end
    end

    // Output port decode: dense read, stream data and last-word flag.
    always_comb begin
        bufferIn_data = '0;
        if (32'(bufferIn_adr) < IN_COUNT) begin
            bufferIn_data = inMem[bufferIn_adr];
        end
        m_axis_tdata = '0;
        if (32'(rdCnt) < OUT_COUNT) begin
            m_axis_tdata = outMem[rdCnt];
        end
    end

    assign s_axis_tready = sReady;
    assign m_axis_tvalid = mValid;
    assign m_axis_tlast  = mValid & rdCo;
    assign gotData       = gotDataReg;
    assign frameErr      = frameErrReg;

endmodule

// File: tb/tb_dense_axis_bridge.sv
// Randomized bench for dense_axis_bridge with IN_COUNT=4, OUT_COUNT=3,
// checked against a frame-level reference model of both buffers.
module tb_dense_axis_bridge;

    localparam int unsigned InCount     = 4;
    localparam int unsigned OutCount    = 3;
    localparam int unsigned DataSize    = 32;
    localparam int unsigned InAdrWidth  = 2;
    localparam int unsigned OutAdrWidth = 2;

    logic                   clk;
    logic                   rst;
    logic [DataSize-1:0]    sData;
    logic                   sValid;
    logic                   sReady;
    logic                   sLast;
    logic [DataSize-1:0]    mData;
    logic                   mValid;
    logic                   mReady;
    logic                   mLast;
    logic [InAdrWidth-1:0]  inAdr;
    logic [DataSize-1:0]    inData;
    logic [OutAdrWidth-1:0] outAdr;
    logic [DataSize-1:0]    outData;
    logic                   outWe;
    logic                   gotData;
    logic                   putData;
    logic                   frameErr;

    dense_axis_bridge #(
        .IN_COUNT      (InCount),
        .OUT_COUNT     (OutCount),
        .DATA_SIZE     (DataSize),
        .IN_ADR_WIDTH  (InAdrWidth),
        .OUT_ADR_WIDTH (OutAdrWidth)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (sData),
        .s_axis_tvalid  (sValid),
        .s_axis_tready  (sReady),
        .s_axis_tlast   (sLast),
        .m_axis_tdata   (mData),
        .m_axis_tvalid  (mValid),
        .m_axis_tready  (mReady),
        .m_axis_tlast   (mLast),
        .bufferIn_adr   (inAdr),
        .bufferIn_data  (inData),
        .bufferOut_adr  (outAdr),
        .bufferOut_data (outData),
        .bufferOut_we   (outWe),
        .gotData        (gotData),
        .putData        (putData),
        .frameErr       (frameErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared;
    int nMismatched;
    int gotCount;

    // Reference model: buffer images, next frame slot, expected sticky error.
    logic [31:0] inModel  [InCount];
    logic [31:0] outModel [OutCount];
    int          wrIdx;
    bit          errExp;

    // Count gotData pulses independently of the directed checks.
    always @(negedge clk) begin
        if (gotData === 1'b1) gotCount++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst     = 1'b0;
        sValid  = 1'b0;
        sLast   = 1'b0;
        mReady  = 1'b0;
        outWe   = 1'b0;
        putData = 1'b0;
        #2;
        checkVal("rst_tready", sReady, 0);
        checkVal("rst_tvalid", mValid, 0);
        checkVal("rst_tlast", mLast, 0);
        checkVal("rst_gotData", gotData, 0);
        checkVal("rst_frameErr", frameErr, 0);
        for (int i = 0; i < OutCount; i++) outModel[i] = '0;
        wrIdx  = 0;
        errExp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        checkVal("tready_after_release", sReady, 1);
    endtask

    task automatic pushWord(input logic [31:0] d, input bit last, input int gap);
        bit ok;
        bit hadReady;
        int guard;
        ok    = 1'b0;
        guard = 0;
        sValid = 1'b0;
        repeat (gap) step();
        sValid = 1'b1;
        sData  = d;
        sLast  = last;
        while (!ok && guard < 20) begin
            hadReady = sReady;
            step();
            ok = hadReady;
            guard++;
        end
        sValid = 1'b0;
        sLast  = 1'b0;
        checkVal("s_handshake", {31'b0, ok}, 1);
    endtask

    task automatic sendFrame(input int n, input int lastAt, input int maxGap, input bit countData);
        logic [31:0] d;
        bit          last;
        bit          done;
        for (int i = 0; i < n; i++) begin
            d    = countData ? 32'(i + 1) : $urandom;
            last = (i == lastAt);
            pushWord(d, last, int'($urandom_range(0, maxGap)));
            done = 1'b0;
            inModel[wrIdx] = d;
            if (wrIdx == InCount - 1) begin
                done = 1'b1;
                if (!last) errExp = 1'b1;
                wrIdx = 0;
            end else if (last) begin
                errExp = 1'b1;
                wrIdx  = 0;
            end else begin
                wrIdx++;
            end
            checkVal($sformatf("gotData_w%0d", i), gotData, {31'b0, done});
            if (done) checkVal("tready_when_full", sReady, 0);
        end
        checkVal("frameErr", frameErr, {31'b0, errExp});
    endtask

    task automatic checkInMem();
        for (int a = 0; a < InCount; a++) begin
            inAdr = InAdrWidth'(a);
            #1;
            checkVal($sformatf("inMem[%0d]", a), inData, inModel[a]);
        end
    endtask

    task automatic writeOut(input logic [OutAdrWidth-1:0] adr, input logic [31:0] d);
        outAdr  = adr;
        outData = d;
        outWe   = 1'b1;
        step();
        outWe = 1'b0;
        if (32'(adr) < OutCount) outModel[adr] = d;
    endtask

    task automatic drainFrame(input bit usePattern, input bit weDuringSend);
        logic [4:0] pat;
        int         idx;
        int         cyc;
        bit         r;
        pat = 5'b10101;
        idx = 0;
        cyc = 0;
        checkVal("tvalid_before_put", mValid, 0);
        putData = 1'b1;
        step();
        putData = 1'b0;
        checkVal("tvalid_after_put", mValid, 1);
        while (idx < OutCount && cyc < 40) begin
            r = usePattern ? pat[cyc % 5] : 1'($urandom_range(0, 1));
            mReady = r;
            checkVal("m_tvalid", mValid, 1);
            checkVal($sformatf("m_tdata[%0d]", idx), mData, outModel[idx]);
            checkVal($sformatf("m_tlast[%0d]", idx), mLast, {31'b0, idx == OutCount - 1});
            if (weDuringSend) begin
                outAdr  = '0;
                outData = 32'hFF;
                outWe   = 1'b1;
            end
            step();
            outWe = 1'b0;
            if (r) idx++;
            cyc++;
        end
        mReady = 1'b0;
        checkVal("send_words", idx, OutCount);
        checkVal("tvalid_after_frame", mValid, 0);
        checkVal("tlast_after_frame", mLast, 0);
        checkVal("back_to_recv", sReady, 1);
    endtask

    initial begin
        int g0;
        int n;
        nCompared   = 0;
        nMismatched = 0;
        gotCount    = 0;
        sData   = '0;
        inAdr   = '0;
        outAdr  = '0;
        outData = '0;
        for (int i = 0; i < InCount; i++) inModel[i] = '0;
        applyReset();

        // putData while receiving must be ignored.
        putData = 1'b1;
        step();
        putData = 1'b0;
        checkVal("put_in_recv_tvalid", mValid, 0);
        checkVal("put_in_recv_tready", sReady, 1);
        step();
        checkVal("put_in_recv_tvalid2", mValid, 0);

        // Words 1..4, no stalls, tlast on the fourth.
        g0 = gotCount;
        sendFrame(4, 3, 0, 1'b1);
        step();
        checkVal("gotData_pulses", gotCount - g0, 1);
        checkVal("gotData_low", gotData, 0);
        checkVal("tready_stays_low", sReady, 0);
        checkInMem();

        // Fill in FULL (adr 3 out of range), stall pattern 1,0,1,0,1, writes in SEND.
        writeOut(2'd0, 32'hA);
        writeOut(2'd1, 32'hB);
        writeOut(2'd2, 32'hC);
        writeOut(2'd3, 32'hDEAD);
        drainFrame(1'b1, 1'b1);

        // Next frame must still carry 0xA at word 0.
        sendFrame(4, 3, 1, 1'b0);
        drainFrame(1'b0, 1'b0);

        // Early tlast drops the frame; the next one starts at slot 0.
        g0 = gotCount;
        sendFrame(2, 1, 0, 1'b0);
        step();
        checkVal("no_gotData_short", gotCount - g0, 0);
        sendFrame(4, 3, 0, 1'b0);
        checkInMem();
        drainFrame(1'b0, 1'b0);

        // Missing tlast on the last word still completes the frame.
        applyReset();
        sendFrame(4, -1, 1, 1'b0);
        checkInMem();
        drainFrame(1'b0, 1'b0);

        // Reset after two words abandons the frame.
        applyReset();
        sendFrame(2, -1, 0, 1'b0);
        applyReset();
        sendFrame(4, 3, 0, 1'b0);
        checkInMem();

        // Reset in the middle of SEND, then outMem must read back as zero.
        writeOut(2'd1, 32'h1234);
        putData = 1'b1;
        step();
        putData = 1'b0;
        mReady = 1'b1;
        step();
        mReady = 1'b0;
        applyReset();
        sendFrame(4, 3, 0, 1'b0);
        checkInMem();
        drainFrame(1'b0, 1'b0);

        // Random rounds.
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(0, 4));
            for (int k = 0; k < n; k++) writeOut(2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(1, 3));
                sendFrame(n, n - 1, 2, 1'b0);
            end
            sendFrame(4, ($urandom_range(0, 1) == 1) ? 3 : -1, 2, 1'b0);
            checkInMem();
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) writeOut(2'($urandom_range(0, 3)), $urandom);
            drainFrame(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
